// File: rtl/ctrl_pkg.sv
// Shared types for the ALUSystem control sequencer: states, opcodes,
// register ids, function codes and the 41-bit control word.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_L,
    S_FETCH_H,
    S_DECODE,
    S_EXEC,
    S_HALT
  } state_t;

  localparam logic [3:0] OP_LDI  = 4'h0;
  localparam logic [3:0] OP_LD   = 4'h1;
  localparam logic [3:0] OP_ST   = 4'h2;
  localparam logic [3:0] OP_LDAR = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_SUB  = 4'h5;
  localparam logic [3:0] OP_AND  = 4'h6;
  localparam logic [3:0] OP_OR   = 4'h7;
  localparam logic [3:0] OP_NOT  = 4'h8;
  localparam logic [3:0] OP_LSL  = 4'h9;
  localparam logic [3:0] OP_BRA  = 4'hA;
  localparam logic [3:0] OP_BEQ  = 4'hB;
  localparam logic [3:0] OP_BNE  = 4'hC;
  localparam logic [3:0] OP_HLT  = 4'hF;

  localparam logic [1:0] ARF_PC = 2'b00;
  localparam logic [1:0] ARF_AR = 2'b01;
  localparam logic [1:0] ARF_SP = 2'b10;

  localparam logic [3:0] RSEL_PC = 4'b0001;
  localparam logic [3:0] RSEL_AR = 4'b0010;
  localparam logic [3:0] RSEL_SP = 4'b0100;

  localparam logic [1:0] FUN_CLR  = 2'b00;
  localparam logic [1:0] FUN_LOAD = 2'b01;
  localparam logic [1:0] FUN_INC  = 2'b10;
  localparam logic [1:0] FUN_DEC  = 2'b11;

  localparam logic [3:0] ALU_PASSA = 4'b0000;
  localparam logic [3:0] ALU_NOT   = 4'b0010;
  localparam logic [3:0] ALU_ADD   = 4'b0100;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_AND   = 4'b0111;
  localparam logic [3:0] ALU_OR    = 4'b1000;
  localparam logic [3:0] ALU_LSL   = 4'b1011;

  typedef struct packed {
    logic [2:0] rf_o1sel;
    logic [2:0] rf_o2sel;
    logic [1:0] rf_funsel;
    logic [3:0] rf_rsel;
    logic [3:0] rf_tsel;
    logic [3:0] alu_funsel;
    logic [1:0] arf_outasel;
    logic [1:0] arf_outbsel;
    logic [1:0] arf_funsel;
    logic [3:0] arf_rsel;
    logic       ir_lh;
    logic       ir_enable;
    logic [1:0] ir_funsel;
    logic       mem_wr;
    logic       mem_cs;
    logic [1:0] mux_asel;
    logic [1:0] mux_bsel;
    logic       mux_csel;
  } ctrl_word_t;

  function automatic ctrl_word_t nop_word();
    ctrl_word_t w;
    w = '0;
    w.mem_cs = 1'b1;
    return w;
  endfunction

  function automatic logic [3:0] rf_onehot(input logic [1:0] r);
    return 4'b1000 >> r;
  endfunction

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational EXEC-cycle decoder: IR contents and Z flag to control word.
// Also flags HLT and the illegal opcodes (D, E) for the sequencer FSM.
import ctrl_pkg::*;

module ctrl_decoder #(
  parameter logic [3:0] HALT_OP = OP_HLT,
  parameter int         IR_W    = 16
) (
  input  logic [IR_W-1:0] ir,
  input  logic            z,
  output ctrl_word_t      word,
  output logic            illegal,
  output logic            halt
);

  logic [3:0] op;
  logic [1:0] rd;
  logic [1:0] rs;
  logic       unused;

  assign op     = ir[15:12];
  assign rd     = ir[11:10];
  assign rs     = ir[9:8];
  assign unused = ^ir[7:0];

  always_comb begin
    word    = nop_word();
    illegal = 1'b0;
    halt    = 1'b0;
    if (op == HALT_OP) begin
      halt = 1'b1;
    end else begin
      unique case (1'b1)
        op == OP_LDI: begin
          word.mux_asel  = 2'b10;
          word.rf_funsel = FUN_LOAD;
          word.rf_rsel   = rf_onehot(rd);
        end
        op == OP_LD: begin
          word.arf_outbsel = ARF_AR;
          word.mem_cs      = 1'b0;
          word.mux_asel    = 2'b01;
          word.rf_funsel   = FUN_LOAD;
          word.rf_rsel     = rf_onehot(rd);
        end
        op == OP_ST: begin
          word.rf_o1sel    = {1'b1, rd};
          word.alu_funsel  = ALU_PASSA;
          word.arf_outbsel = ARF_AR;
          word.mem_cs      = 1'b0;
          word.mem_wr      = 1'b1;
        end
        op == OP_LDAR: begin
          word.mux_bsel   = 2'b10;
          word.arf_funsel = FUN_LOAD;
          word.arf_rsel   = RSEL_AR;
        end
        op >= OP_ADD && op <= OP_LSL: begin
          word.rf_o1sel  = {1'b1, rd};
          word.rf_o2sel  = {1'b1, rs};
          word.mux_asel  = 2'b00;
          word.rf_funsel = FUN_LOAD;
          word.rf_rsel   = rf_onehot(rd);
          unique case (op)
            OP_ADD:  word.alu_funsel = ALU_ADD;
            OP_SUB:  word.alu_funsel = ALU_SUB;
            OP_AND:  word.alu_funsel = ALU_AND;
            OP_OR:   word.alu_funsel = ALU_OR;
            OP_NOT:  word.alu_funsel = ALU_NOT;
            default: word.alu_funsel = ALU_LSL;
          endcase
        end
        op == OP_BRA || (op == OP_BEQ && z) || (op == OP_BNE && !z): begin
          word.mux_bsel   = 2'b10;
          word.arf_funsel = FUN_LOAD;
          word.arf_rsel   = RSEL_PC;
        end
        op == 4'hD || op == 4'hE: illegal = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Four-cycle fetch/decode/execute sequencer driving ALUSystem controls.
// Define CTRL_ILLEGAL_TRAP_EN to halt on D/E opcodes and add the Illegal port.
import ctrl_pkg::*;

module control_sequencer #(
  parameter logic [3:0] HALT_OP = 4'hF,
  parameter int         IR_W    = 16
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic [IR_W-1:0] IR_Out,
  input  logic [3:0]      ALU_FlagOut,
  output logic [2:0]      RF_O1Sel,
  output logic [2:0]      RF_O2Sel,
  output logic [1:0]      RF_FunSel,
  output logic [3:0]      RF_RSel,
  output logic [3:0]      RF_TSel,
  output logic [3:0]      ALU_FunSel,
  output logic [1:0]      ARF_OutASel,
  output logic [1:0]      ARF_OutBSel,
  output logic [1:0]      ARF_FunSel,
  output logic [3:0]      ARF_RSel,
  output logic            IR_LH,
  output logic            IR_Enable,
  output logic [1:0]      IR_Funsel,
  output logic            Mem_WR,
  output logic            Mem_CS,
  output logic [1:0]      MuxASel,
  output logic [1:0]      MuxBSel,
  output logic            MuxCSel,
  output logic            Halted,
  output logic [2:0]      SeqState
`ifdef CTRL_ILLEGAL_TRAP_EN
  ,
  output logic            Illegal
`endif
);

`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  state_t     state;
  state_t     state_nx;
  ctrl_word_t dec_word;
  ctrl_word_t word;
  logic       dec_illegal;
  logic       dec_halt;
  logic       unused;

  assign unused = ^ALU_FlagOut[2:0];

  ctrl_decoder #(
    .HALT_OP(HALT_OP),
    .IR_W   (IR_W)
  ) u_dec (
    .ir     (IR_Out),
    .z      (ALU_FlagOut[3]),
    .word   (dec_word),
    .illegal(dec_illegal),
    .halt   (dec_halt)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:    state_nx = S_FETCH_L;
      S_FETCH_L: state_nx = S_FETCH_H;
      S_FETCH_H: state_nx = S_DECODE;
      S_DECODE:  state_nx = S_EXEC;
      S_EXEC:
        if (dec_halt || (TRAP && dec_illegal)) state_nx = S_HALT;
        else                                   state_nx = S_FETCH_L;
      default:   state_nx = S_HALT;
    endcase
  end

  always_comb begin
    word = nop_word();
    unique case (state)
      S_IDLE: begin
        word.arf_rsel   = RSEL_PC;
        word.arf_funsel = FUN_CLR;
      end
      S_FETCH_L, S_FETCH_H: begin
        word.arf_outbsel = ARF_PC;
        word.mem_cs      = 1'b0;
        word.mem_wr      = 1'b0;
        word.ir_enable   = 1'b1;
        word.ir_lh       = (state == S_FETCH_H);
        word.ir_funsel   = FUN_LOAD;
        word.arf_rsel    = RSEL_PC;
        word.arf_funsel  = FUN_INC;
      end
      S_EXEC:  word = dec_word;
      default: ;
    endcase
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset)
      Illegal <= 1'b0;
    else if (state == S_EXEC && dec_illegal)
      Illegal <= 1'b1;
  end
`endif

  assign RF_O1Sel    = word.rf_o1sel;
  assign RF_O2Sel    = word.rf_o2sel;
  assign RF_FunSel   = word.rf_funsel;
  assign RF_RSel     = word.rf_rsel;
  assign RF_TSel     = word.rf_tsel;
  assign ALU_FunSel  = word.alu_funsel;
  assign ARF_OutASel = word.arf_outasel;
  assign ARF_OutBSel = word.arf_outbsel;
  assign ARF_FunSel  = word.arf_funsel;
  assign ARF_RSel    = word.arf_rsel;
  assign IR_LH       = word.ir_lh;
  assign IR_Enable   = word.ir_enable;
  assign IR_Funsel   = word.ir_funsel;
  assign Mem_WR      = word.mem_wr;
  assign Mem_CS      = word.mem_cs;
  assign MuxASel     = word.mux_asel;
  assign MuxBSel     = word.mux_bsel;
  assign MuxCSel     = word.mux_csel;
  assign Halted      = (state == S_HALT);
  assign SeqState    = state;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: vector table, random
// instructions against a behavioural model, reset/halt/illegal corners.
module tb_control_sequencer;

  typedef struct packed {
    logic [2:0] o1;
    logic [2:0] o2;
    logic [1:0] rf;
    logic [3:0] rsel;
    logic [3:0] tsel;
    logic [3:0] alu;
    logic [1:0] outa;
    logic [1:0] outb;
    logic [1:0] arff;
    logic [3:0] arfr;
    logic       lh;
    logic       ire;
    logic [1:0] irf;
    logic       wr;
    logic       cs;
    logic [1:0] ma;
    logic [1:0] mb;
    logic       mc;
  } cw_t;

  typedef struct {
    logic [15:0] ir;
    logic        z;
    cw_t         exp;
  } vec_t;

  localparam int ST_IDLE = 0, ST_FL = 1, ST_FH = 2, ST_DEC = 3;
  localparam int ST_EXEC = 4, ST_HALT = 5;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic [15:0] IR_Out = '0;
  logic [3:0]  ALU_FlagOut = '0;
  logic [2:0]  RF_O1Sel, RF_O2Sel;
  logic [1:0]  RF_FunSel;
  logic [3:0]  RF_RSel, RF_TSel, ALU_FunSel;
  logic [1:0]  ARF_OutASel, ARF_OutBSel, ARF_FunSel;
  logic [3:0]  ARF_RSel;
  logic        IR_LH, IR_Enable;
  logic [1:0]  IR_Funsel;
  logic        Mem_WR, Mem_CS;
  logic [1:0]  MuxASel, MuxBSel;
  logic        MuxCSel, Halted;
  logic [2:0]  SeqState;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic        Illegal;
`endif

  int tests = 0;
  int fails = 0;

  control_sequencer dut (
    .Clock(Clock), .Reset(Reset), .IR_Out(IR_Out),
    .ALU_FlagOut(ALU_FlagOut),
    .RF_O1Sel(RF_O1Sel), .RF_O2Sel(RF_O2Sel),
    .RF_FunSel(RF_FunSel), .RF_RSel(RF_RSel),
    .RF_TSel(RF_TSel), .ALU_FunSel(ALU_FunSel),
    .ARF_OutASel(ARF_OutASel), .ARF_OutBSel(ARF_OutBSel),
    .ARF_FunSel(ARF_FunSel), .ARF_RSel(ARF_RSel),
    .IR_LH(IR_LH), .IR_Enable(IR_Enable),
    .IR_Funsel(IR_Funsel), .Mem_WR(Mem_WR), .Mem_CS(Mem_CS),
    .MuxASel(MuxASel), .MuxBSel(MuxBSel), .MuxCSel(MuxCSel),
    .Halted(Halted), .SeqState(SeqState)
`ifdef CTRL_ILLEGAL_TRAP_EN
    , .Illegal(Illegal)
`endif
  );

  always #5 Clock = ~Clock;

  function automatic cw_t dut_word();
    return {RF_O1Sel, RF_O2Sel, RF_FunSel, RF_RSel, RF_TSel,
            ALU_FunSel, ARF_OutASel, ARF_OutBSel, ARF_FunSel,
            ARF_RSel, IR_LH, IR_Enable, IR_Funsel, Mem_WR, Mem_CS,
            MuxASel, MuxBSel, MuxCSel};
  endfunction

  function automatic cw_t nopw();
    cw_t w = '0;
    w.cs = 1'b1;
    return w;
  endfunction

  function automatic cw_t idlew();
    cw_t w = nopw();
    w.arfr = 4'b0001;
    return w;
  endfunction

  function automatic cw_t fetchw(input logic lh);
    cw_t w = nopw();
    w.cs   = 1'b0;
    w.ire  = 1'b1;
    w.lh   = lh;
    w.irf  = 2'b01;
    w.arfr = 4'b0001;
    w.arff = 2'b10;
    return w;
  endfunction

  function automatic cw_t mk(input logic [2:0] o1, o2,
                             input logic [1:0] rf,
                             input logic [3:0] rsel, alu,
                             input logic [1:0] outb, arff,
                             input logic [3:0] arfr,
                             input logic cs, wr,
                             input logic [1:0] ma, mb);
    cw_t w = '0;
    w.o1 = o1; w.o2 = o2; w.rf = rf; w.rsel = rsel; w.alu = alu;
    w.outb = outb; w.arff = arff; w.arfr = arfr;
    w.cs = cs; w.wr = wr; w.ma = ma; w.mb = mb;
    return w;
  endfunction

  // Reference: what each instruction must drive in its execute cycle.
  function automatic cw_t exec_model(input logic [15:0] ir,
                                     input logic z);
    logic [3:0] alu_tbl [6] = '{4'd4, 4'd6, 4'd7, 4'd8, 4'd2, 4'd11};
    int op = int'(ir[15:12]);
    int rd = int'(ir[11:10]);
    int rs = int'(ir[9:8]);
    logic [3:0] onehot = 4'(8 >> rd);
    cw_t w = nopw();
    if (op == 0) begin
      w.ma = 2; w.rf = 1; w.rsel = onehot;
    end else if (op == 1) begin
      w.outb = 1; w.cs = 0; w.ma = 1; w.rf = 1; w.rsel = onehot;
    end else if (op == 2) begin
      w.o1 = 3'(4 + rd); w.outb = 1; w.cs = 0; w.wr = 1;
    end else if (op == 3) begin
      w.mb = 2; w.arff = 1; w.arfr = 4'b0010;
    end else if (op >= 4 && op <= 9) begin
      w.o1 = 3'(4 + rd); w.o2 = 3'(4 + rs);
      w.alu = alu_tbl[op - 4]; w.rf = 1; w.rsel = onehot;
    end else if (op == 10 || (op == 11 && z) || (op == 12 && !z)) begin
      w.mb = 2; w.arff = 1; w.arfr = 4'b0001;
    end
    return w;
  endfunction

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic phase(input string name, input int st, input cw_t exp);
    chk({name, " state"}, 64'(SeqState), 64'(st));
    chk({name, " word"}, 64'(dut_word()), 64'(exp));
  endtask

  task automatic run_instr(input logic [15:0] ir, input logic z,
                           input cw_t exp_exec);
    @(negedge Clock); IR_Out = 16'hxxxx; #1;
    phase("fetch_l", ST_FL, fetchw(1'b0));
    @(negedge Clock); #1;
    phase("fetch_h", ST_FH, fetchw(1'b1));
    @(negedge Clock); IR_Out = ir; #1;
    phase("decode", ST_DEC, nopw());
    @(negedge Clock); ALU_FlagOut = {z, 3'b101}; #1;
    phase($sformatf("exec %h z%0d", ir, z), ST_EXEC, exp_exec);
  endtask

  task automatic release_reset();
    @(posedge Clock); #1 Reset = 1'b1;
    @(negedge Clock); #1;
    phase("idle", ST_IDLE, idlew());
  endtask

  vec_t vecs[$];

  initial begin
    vecs.push_back('{16'h0405, 1'b0, mk(0, 0, 1, 4'b0100, 0, 0, 0, 0, 1, 0, 2, 0)});
    vecs.push_back('{16'h0803, 1'b0, mk(0, 0, 1, 4'b0010, 0, 0, 0, 0, 1, 0, 2, 0)});
    vecs.push_back('{16'h4600, 1'b0, mk(5, 6, 1, 4'b0100, 4, 0, 0, 0, 1, 0, 0, 0)});
    vecs.push_back('{16'h3040, 1'b0, mk(0, 0, 0, 0, 0, 0, 1, 4'b0010, 1, 0, 0, 2)});
    vecs.push_back('{16'h2400, 1'b0, mk(5, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0)});
    vecs.push_back('{16'h1C00, 1'b0, mk(0, 0, 1, 4'b0001, 0, 1, 0, 0, 0, 0, 1, 0)});
    vecs.push_back('{16'h5500, 1'b1, mk(5, 5, 1, 4'b0100, 6, 0, 0, 0, 1, 0, 0, 0)});
    vecs.push_back('{16'hB020, 1'b1, mk(0, 0, 0, 0, 0, 0, 1, 4'b0001, 1, 0, 0, 2)});
    vecs.push_back('{16'hB020, 1'b0, nopw()});
    vecs.push_back('{16'hC020, 1'b1, nopw()});
    vecs.push_back('{16'hC020, 1'b0, mk(0, 0, 0, 0, 0, 0, 1, 4'b0001, 1, 0, 0, 2)});
    vecs.push_back('{16'hA055, 1'b0, mk(0, 0, 0, 0, 0, 0, 1, 4'b0001, 1, 0, 0, 2)});
    vecs.push_back('{16'h8800, 1'b0, mk(6, 4, 1, 4'b0010, 2, 0, 0, 0, 1, 0, 0, 0)});
    vecs.push_back('{16'h9000, 1'b0, mk(4, 4, 1, 4'b1000, 11, 0, 0, 0, 1, 0, 0, 0)});
    vecs.push_back('{16'h7D00, 1'b0, mk(7, 5, 1, 4'b0001, 8, 0, 0, 0, 1, 0, 0, 0)});
    vecs.push_back('{16'h6300, 1'b0, mk(4, 7, 1, 4'b1000, 7, 0, 0, 0, 1, 0, 0, 0)});

    // Reset state
    repeat (2) @(negedge Clock);
    #1 phase("reset", ST_IDLE, idlew());
    chk("reset halted", 64'(Halted), 64'd0);
    release_reset();

    foreach (vecs[i]) run_instr(vecs[i].ir, vecs[i].z, vecs[i].exp);

    // Illegal opcodes
`ifdef CTRL_ILLEGAL_TRAP_EN
    run_instr(16'hD000, 1'b0, nopw());
    @(negedge Clock); #1;
    phase("trap", ST_HALT, nopw());
    chk("trap halted", 64'(Halted), 64'd1);
    chk("trap illegal", 64'(Illegal), 64'd1);
    Reset = 1'b0; #1;
    chk("illegal cleared", 64'(Illegal), 64'd0);
    release_reset();
`else
    run_instr(16'hD000, 1'b0, nopw());
    run_instr(16'hE3FF, 1'b1, nopw());
    run_instr(16'h0405, 1'b0, exec_model(16'h0405, 1'b0));
`endif

    // Random instructions (HLT and illegal codes excluded)
    for (int n = 0; n < 60; n++) begin
      logic [15:0] ir;
      logic        z;
      ir = 16'($urandom);
      ir[15:12] = 4'($urandom_range(0, 12));
      z = 1'($urandom);
      run_instr(ir, z, exec_model(ir, z));
    end

    // Reset asserted in the middle of EXEC
    run_instr(16'h4600, 1'b0, exec_model(16'h4600, 1'b0));
    @(negedge Clock); IR_Out = 16'h0000; #1;
    @(negedge Clock); #1;
    @(negedge Clock); IR_Out = 16'h2400; #1;
    @(negedge Clock); #1;
    chk("pre-reset exec", 64'(SeqState), 64'(ST_EXEC));
    #1 Reset = 1'b0; #1;
    chk("async reset state", 64'(SeqState), 64'(ST_IDLE));
    chk("async reset cs", 64'(Mem_CS), 64'd1);
    chk("async reset word", 64'(dut_word()), 64'(idlew()));
    release_reset();
    run_instr(16'h0405, 1'b0, exec_model(16'h0405, 1'b0));

    // HLT is sticky and stops fetching
    run_instr(16'hF000, 1'b0, nopw());
    for (int c = 0; c < 20; c++) begin
      @(negedge Clock); IR_Out = 16'($urandom); #1;
      phase("halt", ST_HALT, nopw());
      chk("halt flag", 64'(Halted), 64'd1);
    end
    Reset = 1'b0; #1;
    chk("halt cleared", 64'(Halted), 64'd0);
    release_reset();
    run_instr(16'h0803, 1'b0, exec_model(16'h0803, 1'b0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
